// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module   : fifo_burst_reader
// Brief    : Pops a programmed burst from a synchronous FIFO read port and
//            streams it on valid/ready through a 2-entry skid buffer.
//            Optional macro FIFO_RD_CNT_EN adds the xfer_cnt output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [LEN_WIDTH-1:0]  xfer_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_sent;
    logic                  r_inflight;
    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;

    logic                  w_pop;
    logic                  w_rd_en;
    logic [2:0]            w_credit;
    logic [LEN_WIDTH-1:0]  w_issued_nxt;
    logic [LEN_WIDTH-1:0]  w_sent_nxt;

    assign w_pop        = (r_count != 2'd0) && m_ready;
    // Occupancy the buffer will have once the in-flight word lands and any pop leaves.
    assign w_credit     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en      = (r_state == S_READ) && !empty && (r_issued < r_len)
                          && (w_credit < 3'd2);
    assign w_issued_nxt = r_issued + LEN_WIDTH'(1);
    assign w_sent_nxt   = r_sent + LEN_WIDTH'(1);

    assign r_en    = w_rd_en;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign m_valid = (r_count != 2'd0);
    assign m_data  = r_buf0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_issued <= '0;
            r_sent   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len    <= burst_len;
                        r_issued <= '0;
                        r_sent   <= '0;
                        r_state  <= (burst_len == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (w_rd_en) begin
                        r_issued <= w_issued_nxt;
                        if (w_issued_nxt == r_len) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && (w_sent_nxt == r_len)) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_pop) begin
                r_sent <= w_sent_nxt;
            end
        end
    end

    // Skid buffer: r_buf0 is the head; rdata lands one cycle after r_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_inflight <= w_rd_en;
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_buf0 <= rdata;
                    end else begin
                        r_buf1 <= rdata;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_buf0  <= r_buf1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf0 <= rdata;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= rdata;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

`ifdef FIFO_RD_CNT_EN
    logic [LEN_WIDTH-1:0] r_xfer_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_xfer_cnt <= '0;
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + LEN_WIDTH'(1);
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

`default_nettype wire
